// File: rtl/demux1t2_4_buf_if.sv
// demux1t2_4_buf_if
//   Handshake bundle for the registered 1-to-2 demux.
//   Input side : d, sel, in_valid -> in_ready
//   Channel A  : a, a_valid -> a_ready, a_count
//   Channel B  : b, b_valid -> b_ready, b_count
//   master = producer/consumer environment, slave = the demux itself.
interface demux1t2_4_buf_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] d;
  logic             sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] a_count;
  logic [CNT_W-1:0] b_count;

  modport master (
    output d, sel, in_valid, a_ready, b_ready,
    input  in_ready, a, a_valid, b, b_valid, a_count, b_count
  );

  modport slave (
    input  d, sel, in_valid, a_ready, b_ready,
    output in_ready, a, a_valid, b, b_valid, a_count, b_count
  );
endinterface

// File: rtl/demux1t2_4_buf.sv
// demux1t2_4_buf
//   Registered 1-to-2 demultiplexer with a one-entry buffer per channel.
//   Ports:
//     clk, rst_n : clock (rising edge), async active-low reset
//     bus        : demux1t2_4_buf_if.slave (input handshake, channels A/B,
//                  per-channel wrapping output-handshake counters)

// One output channel: EMPTY/FULL buffer plus handshake counter.
module demux1t2_4_buf_chan #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,     // accepted input word steered here
  input  logic [WIDTH-1:0] wdata,
  input  logic             rdy,    // consumer ready
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic [CNT_W-1:0] cnt
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    drain   = (state_q == FULL) && rdy;
    if (drain) cnt_d = cnt_q + CNT_W'(1);
    // Data is only ever overwritten by a write; an empty buffer keeps
    // showing the last word it held.
    if (wr) data_d = wdata;
    unique case (state_q)
      EMPTY: if (wr) state_d = FULL;
      FULL:  if (drain && !wr) state_d = EMPTY;  // drain+write stays FULL
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data = data_q;
  assign vld  = (state_q == FULL);
  assign cnt  = cnt_q;
endmodule

module demux1t2_4_buf #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  demux1t2_4_buf_if.slave       bus
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
  logic [NUM_CH-1:0]            ch_vld;
  logic [NUM_CH-1:0]            ch_rdy;
  logic [NUM_CH-1:0]            ch_wr;
  logic                         acc;

  assign ch_rdy = {bus.b_ready, bus.a_ready};

  // Ready depends only on the selected channel, so a stalled channel never
  // blocks traffic to the other one.
  assign bus.in_ready = !ch_vld[bus.sel] || ch_rdy[bus.sel];
  assign acc          = bus.in_valid && bus.in_ready;
  assign ch_wr        = {acc && bus.sel, acc && !bus.sel};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    demux1t2_4_buf_chan #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (ch_wr[g]),
      .wdata (bus.d),
      .rdy   (ch_rdy[g]),
      .data  (ch_data[g]),
      .vld   (ch_vld[g]),
      .cnt   (ch_cnt[g])
    );
  end

  assign bus.a       = ch_data[0];
  assign bus.a_valid = ch_vld[0];
  assign bus.a_count = ch_cnt[0];
  assign bus.b       = ch_data[1];
  assign bus.b_valid = ch_vld[1];
  assign bus.b_count = ch_cnt[1];
endmodule

// File: tb/tb_demux1t2_4_buf.sv
module tb_demux1t2_4_buf;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  demux1t2_4_buf_if #(.WIDTH(4), .CNT_W(8)) bus ();

  demux1t2_4_buf #(.WIDTH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each channel is a one-slot store with a handshake tally.
  logic       m_v [2];
  logic [3:0] m_d [2];
  int         m_c [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0;
      m_d[i] = 4'd0;
      m_c[i] = 0;
    end
  endtask

  task automatic check_outs(input string ph);
    chk({ph, ":a"},       32'(bus.a),       32'(m_d[0]));
    chk({ph, ":a_valid"}, 32'(bus.a_valid), 32'(m_v[0]));
    chk({ph, ":b"},       32'(bus.b),       32'(m_d[1]));
    chk({ph, ":b_valid"}, 32'(bus.b_valid), 32'(m_v[1]));
    chk({ph, ":a_count"}, 32'(bus.a_count), 32'(m_c[0] % 256));
    chk({ph, ":b_count"}, 32'(bus.b_count), 32'(m_c[1] % 256));
  endtask

  // One clock cycle: drive, check in_ready, advance model, check registered outputs.
  task automatic step(input string ph, input logic iv, input logic s,
                      input logic [3:0] dd, input logic ar, input logic br);
    logic rdy;
    logic r [2];
    bus.in_valid = iv;
    bus.sel      = s;
    bus.d        = dd;
    bus.a_ready  = ar;
    bus.b_ready  = br;
    r[0] = ar;
    r[1] = br;
    #1;
    rdy = !m_v[s] || r[s];
    chk({ph, ":in_ready"}, 32'(bus.in_ready), 32'(rdy));
    for (int i = 0; i < 2; i++)
      if (m_v[i] && r[i]) begin
        m_c[i]++;
        m_v[i] = 1'b0;
      end
    if (iv && rdy) begin
      m_v[s] = 1'b1;
      m_d[s] = dd;
    end
    @(posedge clk);
    #1;
    check_outs(ph);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.sel      = 1'b0;
    bus.d        = 4'd0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
    model_reset();

    // Asynchronous reset, asserted mid-cycle.
    #3 rst_n = 1'b0;
    #2;
    check_outs("reset");
    chk("reset:in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle: nothing may change.
    for (int i = 0; i < 10; i++)
      step("idle", 1'b0, 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));

    // Basic routing.
    step("route_a", 1'b1, 1'b0, 4'b1010, 1'b1, 1'b0);
    step("route_a2", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    step("route_b", 1'b1, 1'b1, 4'b0001, 1'b0, 1'b1);
    step("route_b2", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Backpressure on A, B still accepts.
    step("bp_fill", 1'b1, 1'b0, 4'b0011, 1'b0, 1'b0);
    step("bp_stall", 1'b1, 1'b0, 4'b0101, 1'b0, 1'b0);
    step("bp_other", 1'b1, 1'b1, 4'b0110, 1'b0, 1'b0);
    step("bp_drain", 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);

    // Full throughput into A.
    for (int i = 0; i < 16; i++)
      step("stream", 1'b1, 1'b0, 4'(i), 1'b1, 1'b0);
    step("stream_end", 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);

    // Counter wrap on B.
    for (int i = 0; i < 256; i++)
      step("wrap", 1'b1, 1'b1, 4'($urandom), 1'b0, 1'b1);
    step("wrap_end", 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 1500; i++)
      step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0));

    // Reset while both channels hold stalled words.
    step("mid_fill_a", 1'b1, 1'b0, 4'hc, 1'b0, 1'b0);
    step("mid_fill_b", 1'b1, 1'b1, 4'h9, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("mid_reset");
    chk("mid_reset:in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step("post", 1'b1, 1'($urandom), 4'($urandom), 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
